// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_W = 32;
  localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] pc_plus4;
    logic [FETCH_W-1:0] instr;
    logic               fault;
  } ifid_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Three saturating 32-bit event counters for the fetch stage; each counts one per
// cycle its strobe is high and sticks at all-ones.
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  input  logic        i_flush_inc,
  output logic [31:0] o_fetched,
  output logic [31:0] o_stall,
  output logic [31:0] o_flush
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall;
  logic [31:0] r_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetched <= '0;
      r_stall   <= '0;
      r_flush   <= '0;
    end else begin
      if (i_fetch_inc) r_fetched <= sat_inc(r_fetched);
      if (i_stall_inc) r_stall   <= sat_inc(r_stall);
      if (i_flush_inc) r_flush   <= sat_inc(r_flush);
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;
  assign o_flush   = r_flush;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select and IF/ID register; one-edge latency, stall holds PC and IF/ID.
// FETCH_PERF_EN enables the saturating perf counters; otherwise perf outputs are tied to 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_PC       = '0,
  parameter int               IMEM_ADDR_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  output logic [WIDTH-1:0] imem_pc_o,
  input  logic [WIDTH-1:0] imem_instr_i,
  output logic             ifid_valid_o,
  output logic [WIDTH-1:0] ifid_pc_o,
  output logic [WIDTH-1:0] ifid_pc_plus4_o,
  output logic [WIDTH-1:0] ifid_instr_o,
  output logic             ifid_fault_o,
  output logic [31:0]      perf_fetched_o,
  output logic [31:0]      perf_stall_o,
  output logic [31:0]      perf_flush_o
);

  // Span is one bit wider so IMEM_ADDR_BITS == WIDTH does not overflow.
  localparam logic [WIDTH:0]   IMEM_SPAN = (WIDTH+1)'(1) << IMEM_ADDR_BITS;
  localparam logic [WIDTH-1:0] IMEM_LAST = WIDTH'(IMEM_SPAN - (WIDTH+1)'(4));

  localparam ifid_t IFID_RESET = '{valid: 1'b0, pc: '0, pc_plus4: 32'd4,
                                   instr: NOP_INSTR, fault: 1'b0};

  fetch_state_t     r_state;
  logic [WIDTH-1:0] r_pc;
  ifid_t            r_ifid;
  logic [WIDTH-1:0] w_pc_plus4;
  logic             w_fault;

  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_fault    = (r_pc[1:0] != 2'b00) | (r_pc > IMEM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_ifid  <= IFID_RESET;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          if (redirect_i) r_pc <= redirect_target_i;
        end
        RUN: begin
          if (redirect_i) begin
            r_pc         <= redirect_target_i;
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
            r_ifid.fault <= 1'b0;
          end else if (!stall_i) begin
            r_ifid.valid    <= 1'b1;
            r_ifid.pc       <= r_pc;
            r_ifid.pc_plus4 <= w_pc_plus4;
            if (w_fault) begin
              // PC stays on the faulting address so it is visible until redirected.
              r_ifid.instr <= NOP_INSTR;
              r_ifid.fault <= 1'b1;
              r_state      <= FAULT;
            end else begin
              r_ifid.instr <= imem_instr_i;
              r_ifid.fault <= 1'b0;
              r_pc         <= w_pc_plus4;
            end
          end
        end
        FAULT: begin
          if (redirect_i) begin
            r_pc         <= redirect_target_i;
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
            r_ifid.fault <= 1'b0;
            r_state      <= RUN;
          end else if (!stall_i) begin
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
            r_ifid.fault <= 1'b0;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign imem_pc_o       = r_pc;
  assign ifid_valid_o    = r_ifid.valid;
  assign ifid_pc_o       = r_ifid.pc;
  assign ifid_pc_plus4_o = r_ifid.pc_plus4;
  assign ifid_instr_o    = r_ifid.instr;
  assign ifid_fault_o    = r_ifid.fault;

`ifdef FETCH_PERF_EN
  logic w_fetch_inc;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_fetch_inc = (r_state == RUN) & ~redirect_i & ~stall_i;
  assign w_stall_inc = (r_state != BOOT) & stall_i & ~redirect_i;
  assign w_flush_inc = redirect_i;

  fetch_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .i_flush_inc (w_flush_inc),
    .o_fetched   (perf_fetched_o),
    .o_stall     (perf_stall_o),
    .o_flush     (perf_flush_o)
  );
`else
  assign perf_fetched_o = '0;
  assign perf_stall_o   = '0;
  assign perf_flush_o   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents queued per step, compared after each edge.
module tb_fetch_stage;
  import fetch_pkg::*;

  typedef struct {
    ifid_t ifid;
    bit    chk_pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_instr_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_fault_o;
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
  logic [31:0] perf_flush_o;

  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t last_exp;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .IMEM_ADDR_BITS(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_pc_o         (imem_pc_o),
    .imem_instr_i      (imem_instr_i),
    .ifid_valid_o      (ifid_valid_o),
    .ifid_pc_o         (ifid_pc_o),
    .ifid_pc_plus4_o   (ifid_pc_plus4_o),
    .ifid_instr_o      (ifid_instr_o),
    .ifid_fault_o      (ifid_fault_o),
    .perf_fetched_o    (perf_fetched_o),
    .perf_stall_o      (perf_stall_o),
    .perf_flush_o      (perf_flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign imem_instr_i = imem_word(imem_pc_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] pc4,
                      input logic [31:0] instr, input logic f, input bit cp);
    exp_t e;
    e.ifid   = '{valid: v, pc: pc, pc_plus4: pc4, instr: instr, fault: f};
    e.chk_pc = cp;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch(input logic [31:0] pc);
    push(1'b1, pc, pc + 32'd4, imem_word(pc), 1'b0, 1'b1);
  endtask

  task automatic push_fault(input logic [31:0] pc);
    push(1'b1, pc, pc + 32'd4, NOP_INSTR, 1'b1, 1'b1);
  endtask

  task automatic push_bubble();
    push(1'b0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b0);
  endtask

  task automatic push_reset();
    push(1'b0, 32'h0, 32'h4, NOP_INSTR, 1'b0, 1'b1);
  endtask

  task automatic push_hold();
    exp_q.push_back(last_exp);
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt,
                       input logic [31:0] exp_imem);
    exp_t e;
    stall_i           = st;
    redirect_i        = rd;
    redirect_target_i = tgt;
    @(posedge clk);
    #1;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e        = exp_q.pop_front();
      last_exp = e;
      chk("ifid_valid", 32'(ifid_valid_o), 32'(e.ifid.valid));
      chk("ifid_instr", ifid_instr_o, e.ifid.instr);
      chk("ifid_fault", 32'(ifid_fault_o), 32'(e.ifid.fault));
      if (e.chk_pc) begin
        chk("ifid_pc", ifid_pc_o, e.ifid.pc);
        chk("ifid_pc_plus4", ifid_pc_plus4_o, e.ifid.pc_plus4);
      end
    end
    chk("imem_pc", imem_pc_o, exp_imem);
  endtask

  task automatic perf_chk(input logic [31:0] f, input logic [31:0] s, input logic [31:0] fl);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched_o, f);
    chk("perf_stall", perf_stall_o, s);
    chk("perf_flush", perf_flush_o, fl);
`else
    chk("perf_fetched", perf_fetched_o, 32'h0);
    chk("perf_stall", perf_stall_o, 32'h0);
    chk("perf_flush", perf_flush_o, 32'h0);
    if (f === 32'hx || s === 32'hx || fl === 32'hx) n_fail++;
`endif
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    stall_i           = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'h0;
    last_exp.ifid     = '{valid: 1'b0, pc: 32'h0, pc_plus4: 32'h4, instr: NOP_INSTR, fault: 1'b0};
    last_exp.chk_pc   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ifid_valid_o), 32'h0);
    chk("rst_pc", ifid_pc_o, 32'h0);
    chk("rst_pc_plus4", ifid_pc_plus4_o, 32'h4);
    chk("rst_instr", ifid_instr_o, NOP_INSTR);
    chk("rst_fault", 32'(ifid_fault_o), 32'h0);
    chk("rst_imem_pc", imem_pc_o, 32'h0);
    perf_chk(32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;

    // BOOT cycle, then the first two fetches
    push_reset();      cycle(1'b0, 1'b0, 32'h0, 32'h0);
    push_fetch(32'h0); cycle(1'b0, 1'b0, 32'h0, 32'h4);
    push_fetch(32'h4); cycle(1'b0, 1'b0, 32'h0, 32'h8);

    for (int i = 0; i < 3; i++) begin
      push_hold();
      cycle(1'b1, 1'b0, 32'h0, 32'h8);
    end
    perf_chk(32'd2, 32'd3, 32'd0);
    push_fetch(32'h8); cycle(1'b0, 1'b0, 32'h0, 32'hC);

    // redirect wins over a simultaneous stall
    push_bubble();      cycle(1'b1, 1'b1, 32'h40, 32'h40);
    perf_chk(32'd3, 32'd3, 32'd1);
    push_fetch(32'h40); cycle(1'b0, 1'b0, 32'h0, 32'h44);

    // misaligned target: fault, frozen PC, bubbles until redirected
    push_bubble();      cycle(1'b0, 1'b1, 32'h42, 32'h42);
    push_fault(32'h42); cycle(1'b0, 1'b0, 32'h0, 32'h42);
    push_bubble();      cycle(1'b0, 1'b0, 32'h0, 32'h42);
    push_hold();        cycle(1'b1, 1'b0, 32'h0, 32'h42);
    push_bubble();      cycle(1'b0, 1'b1, 32'h10, 32'h10);
    push_fetch(32'h10); cycle(1'b0, 1'b0, 32'h0, 32'h14);

    // top of the instruction memory and the first address past it
    push_bubble();         cycle(1'b0, 1'b1, 32'hFFFC, 32'hFFFC);
    push_fetch(32'hFFFC);  cycle(1'b0, 1'b0, 32'h0, 32'h1_0000);
    push_fault(32'h1_0000); cycle(1'b0, 1'b0, 32'h0, 32'h1_0000);

    // PC+4 wraps to zero
    push_bubble();             cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    push_fault(32'hFFFF_FFFC); cycle(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", ifid_pc_plus4_o, 32'h0);

    push_bubble();      cycle(1'b0, 1'b1, 32'h20, 32'h20);
    push_fetch(32'h20); cycle(1'b0, 1'b0, 32'h0, 32'h24);
    perf_chk(32'd10, 32'd4, 32'd6);

    // asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ifid_valid_o), 32'h0);
    chk("async_rst_instr", ifid_instr_o, NOP_INSTR);
    chk("async_rst_imem_pc", imem_pc_o, 32'h0);
    perf_chk(32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_reset();      cycle(1'b0, 1'b0, 32'h0, 32'h0);
    push_fetch(32'h0); cycle(1'b0, 1'b0, 32'h0, 32'h4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage with the PC register, next-PC selection and the IF/ID pipeline register. Drives the byte address into the combinational, little-endian, byte-addressed instruction memory. Latches the returned 32-bit word together with its PC for the decode stage. Handles stall, branch/jump redirect (flush) and fetch-fault detection.

Parameters:
WIDTH, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_ADDR_BITS, 16, byte-address bits implemented by the instruction memory (valid range 0 .. 2**IMEM_ADDR_BITS-4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
stall_i  input  1  decode hazard; hold PC and IF/ID contents
redirect_i  input  1  taken branch/jump from execute; flush and reload PC
redirect_target_i  input  WIDTH  new PC when redirect_i=1
imem_pc_o  output  WIDTH  byte address to instruction memory (= pc_q, combinational)
imem_instr_i  input  WIDTH  instruction word returned combinationally
ifid_valid_o  output  1  IF/ID holds a real instruction
ifid_pc_o  output  WIDTH  PC of latched instruction
ifid_pc_plus4_o  output  WIDTH  ifid_pc_o + 4, modulo 2**WIDTH
ifid_instr_o  output  WIDTH  latched instruction word
ifid_fault_o  output  1  latched fetch was misaligned or out of range
perf_fetched_o  output  32  valid fetches counted (FETCH_PERF_EN)
perf_stall_o  output  32  stall cycles counted (FETCH_PERF_EN)
perf_flush_o  output  32  redirects counted (FETCH_PERF_EN)

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC, state=BOOT.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_pc_plus4_o=4, ifid_instr_o=NOP (32'h0000_0013), ifid_fault_o=0, perf counters=0.
  - Assertion mid-operation discards all in-flight state immediately.
- fault_c = (pc_q[1:0]!=0) | (pc_q > 2**IMEM_ADDR_BITS-4). Computed combinationally on pc_q.
- FSM states: BOOT, RUN, FAULT.
  - BOOT: one cycle after reset release. No capture; pc_q held; ifid_valid_o stays 0. Next state RUN (a redirect in BOOT is honoured and also goes to RUN).
  - RUN: per-edge priority is redirect > stall > advance.
    - Redirect: pc_q<=redirect_target_i; IF/ID<=bubble (valid=0, instr=NOP, fault=0). Applies even while stall_i=1.
    - Stall (no redirect): pc_q and IF/ID hold unchanged.
    - Advance, fault_c=0: IF/ID<={valid=1, pc_q, pc_q+4, imem_instr_i, fault=0}; pc_q<=pc_q+4.
    - Advance, fault_c=1: IF/ID<={valid=1, pc_q, pc_q+4, NOP, fault=1}; pc_q held; state<=FAULT.
  - FAULT: pc_q frozen. On each non-stalled cycle, IF/ID is loaded with a bubble (valid=0). Only redirect_i leaves FAULT: pc_q<=target, IF/ID bubble, state<=RUN.
- Latency: instruction at PC p appears on ifid_* one edge after pc_q=p, with no stall or redirect that cycle.
- Arithmetic: all PC additions are WIDTH-bit, wrapping modulo 2**WIDTH (32'hFFFF_FFFC+4=0). The out-of-range check catches the wrapped value.
- Redirect targets are not realigned; a misaligned target faults on its first advance.

Optional Feature:
FETCH_PERF_EN
- Defined: three 32-bit saturating counters (stop at 32'hFFFF_FFFF).
  - perf_fetched_o counts edges loading valid=1.
  - perf_stall_o counts RUN/FAULT cycles with stall_i=1 and redirect_i=0.
  - perf_flush_o counts accepted redirects.
  - All cleared by rst_n.
- Undefined: ports remain, tied to 0; no counter flops are generated.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {BOOT, RUN, FAULT}.
  - ifid_t packed struct {valid, pc, pc_plus4, instr, fault}.
- Sub-module fetch_perf_counters: three saturating counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset release, RESET_PC=0, imem words 0x00500093, 0x00A00113, no stall -> edge1: valid=0 (BOOT); edge2: ifid_pc=0, instr=0x00500093; edge3: ifid_pc=4, instr=0x00A00113.
- stall_i=1 for 3 cycles at pc_q=8 -> pc_q stays 8, ifid unchanged; with FETCH_PERF_EN, perf_stall_o=3.
- redirect_i=1, target=0x40, stall_i=1 same cycle -> next edge pc_q=0x40, ifid_valid=0, ifid_instr=0x00000013; perf_flush_o +1.
- Redirect to 0x42 -> first advance latches valid=1, fault=1, instr=NOP, state FAULT, pc_q stays 0x42. Then redirect to 0x10 -> RUN, fetch resumes at 0x10.
- pc_q=0xFFFC, IMEM_ADDR_BITS=16 -> normal fetch. Next pc_q=0x10000 -> fault=1. Separately, pc_q=0xFFFFFFFC -> ifid_pc_plus4_o=0.
- rst_n asserted mid-stream at pc_q=0x24 -> asynchronously valid=0, pc_q=RESET_PC, counters 0. After release, BOOT cycle repeats.
